// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel packet serialiser.
// PACKER_CHECKSUM_EN selects the 5-byte packet with trailing checksum.
package pixel_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_WAIT_ACK,
      ST_WAIT_DONE,
      ST_DONE
   } state_t;

   localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

   localparam logic [2:0] IDX_HDR  = 3'd0;
   localparam logic [2:0] IDX_SEQ  = 3'd1;
   localparam logic [2:0] IDX_HI   = 3'd2;
   localparam logic [2:0] IDX_LO   = 3'd3;
   localparam logic [2:0] IDX_CSUM = 3'd4;

`ifdef PACKER_CHECKSUM_EN
   localparam logic [2:0] IDX_LAST = IDX_CSUM;
`else
   localparam logic [2:0] IDX_LAST = IDX_LO;
`endif

   function automatic logic [7:0] pkt_byte(input logic [2:0]  idx,
                                           input logic [7:0]  hdr,
                                           input logic [7:0]  seq,
                                           input logic [15:0] sample);
      pkt_byte = 8'h00;
      case (idx)
         IDX_HDR:  pkt_byte = hdr;
         IDX_SEQ:  pkt_byte = seq;
         IDX_HI:   pkt_byte = sample[15:8];
         IDX_LO:   pkt_byte = sample[7:0];
`ifdef PACKER_CHECKSUM_EN
         IDX_CSUM: pkt_byte = seq ^ sample[15:8] ^ sample[7:0];
`else
         IDX_CSUM: pkt_byte = 8'h00;
`endif
         default:  pkt_byte = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; head visible the cycle after the push.
// Pushes while full and pops while empty are ignored; full/empty come from registered pointers.
module sample_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer bit distinguishes full from empty when the addresses match.
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_in) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/pixel_frame_packer.sv
// Buffers ADC samples and sends each as HEADER,seq,hi,lo[,checksum when PACKER_CHECKSUM_EN] to a UART.
// First tx_start two cycles after a sample is accepted; sample_ready drops while the FIFO is full.
module pixel_frame_packer
   import pixel_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] HEADER     = DEFAULT_HEADER
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic [15:0] sample_data,
   output logic        sample_ready,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic        overflow,
   output logic [7:0]  pkt_count
);

   state_t      state_q;
   state_t      state_d;
   logic [15:0] sample_q;
   logic [2:0]  byte_idx_q;
   logic [7:0]  seq_q;
   logic [7:0]  tx_data_q;
   logic        overflow_q;

   logic        fifo_push;
   logic        fifo_pop;
   logic [15:0] fifo_dout;
   logic        fifo_full;
   logic        fifo_empty;
   logic        more_bytes;

   assign sample_ready = !fifo_full;
   assign fifo_push    = sample_valid && !fifo_full;
   assign more_bytes   = (byte_idx_q < IDX_LAST);
   assign tx_data      = tx_data_q;
   assign overflow     = overflow_q;
   // Sequence number and sent-packet count advance together, so one register serves both.
   assign pkt_count    = seq_q;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk_in    (clk_in),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (sample_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      tx_start = 1'b0;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE:      if (!fifo_empty) state_d = ST_LOAD;
         ST_LOAD: begin
            fifo_pop = 1'b1;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK:  if (tx_busy) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (!tx_busy) state_d = more_bytes ? ST_SEND : ST_DONE;
         ST_DONE:      state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sample_q   <= '0;
         byte_idx_q <= '0;
         seq_q      <= '0;
         tx_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (sample_valid && fifo_full) overflow_q <= 1'b1;
         // tx_data is staged one state ahead so it is already stable when tx_start fires.
         case (state_q)
            ST_LOAD: begin
               sample_q   <= fifo_dout;
               byte_idx_q <= '0;
               tx_data_q  <= HEADER;
            end
            ST_WAIT_DONE: begin
               if (!tx_busy && more_bytes) begin
                  byte_idx_q <= byte_idx_q + 3'd1;
                  tx_data_q  <= pkt_byte(byte_idx_q + 3'd1, HEADER, seq_q, sample_q);
               end
            end
            ST_DONE: seq_q <= seq_q + 8'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pixel_frame_packer.sv
// Self-checking bench for pixel_frame_packer with a simple UART busy model and byte scoreboard.
module tb_pixel_frame_packer;

`ifdef PACKER_CHECKSUM_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif

   logic        clk_in = 1'b0;
   logic        reset = 1'b1;
   logic        sample_valid = 1'b0;
   logic [15:0] sample_data = 16'h0000;
   logic        tx_busy = 1'b0;
   logic        sample_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        overflow;
   logic [7:0]  pkt_count;

   int   errors = 0;
   int   checks = 0;

   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [7:0] exp_seq = 8'h00;
   int         busy_len = 10;
   bit         hold_busy = 1'b0;
   int         busy_cnt = 0;
   bit         start_pend = 1'b0;

   pixel_frame_packer dut (
      .clk_in       (clk_in),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .tx_busy      (tx_busy),
      .overflow     (overflow),
      .pkt_count    (pkt_count)
   );

   always #10 clk_in = ~clk_in;

   // UART model: capture bytes on tx_start, then hold busy for busy_len cycles.
   initial begin
      forever begin
         @(negedge clk_in);
         start_pend = 1'b0;
         if (tx_start === 1'b1) begin
            got_q.push_back(tx_data);
            start_pend = 1'b1;
         end
         @(posedge clk_in);
         #1;
         if (hold_busy) tx_busy = 1'b1;
         else if (start_pend) begin
            tx_busy  = 1'b1;
            busy_cnt = busy_len;
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
         end else tx_busy = 1'b0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      hold_busy = 1'b0;
      tick(2);
      reset = 1'b0;
      exp_q.delete();
      got_q.delete();
      exp_seq = 8'h00;
   endtask

   task automatic drive_push(input logic [15:0] d);
      sample_valid = 1'b1;
      sample_data  = d;
      tick(1);
      sample_valid = 1'b0;
   endtask

   task automatic expect_packet(input logic [15:0] d);
      exp_q.push_back(8'hA5);
      exp_q.push_back(exp_seq);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
      if (NB == 5) exp_q.push_back(exp_seq ^ d[15:8] ^ d[7:0]);
      exp_seq = exp_seq + 8'd1;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int w = 0;
      while (got_q.size() < n && w < budget) begin
         tick(1);
         w++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks += 5;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
      if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
      if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      if (pkt_count !== 8'h00) begin errors++; $display("FAIL reset_pkt_count: got %h want 00", pkt_count); end
   endtask

   task automatic test_single();
      apply_reset();
      busy_len = 10;
      drive_push(16'h0ABC);
      expect_packet(16'h0ABC);
      checks++;
      if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_n: got %b want 0", tx_start); end
      tick(1);
      checks++;
      if (tx_start !== 1'b0) begin errors++; $display("FAIL single_start_n1: got %b want 0", tx_start); end
      tick(1);
      checks += 2;
      if (tx_start !== 1'b1) begin errors++; $display("FAIL single_start_n2: got %b want 1", tx_start); end
      if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_first_byte: got %h want a5", tx_data); end
      wait_bytes(NB, 500);
      tick(busy_len + 8);
      checks++;
      if (got_q.size() != NB) begin
         errors++; $display("FAIL single_count: got %0d want %0d", got_q.size(), NB);
      end else begin
         for (int i = 0; i < NB; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
         end
      end
      checks++;
      if (pkt_count !== 8'd1) begin errors++; $display("FAIL single_pkt_count: got %0d want 1", pkt_count); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] d;
      apply_reset();
      busy_len = 10;
      for (int i = 0; i < 4; i++) begin
         d = 16'h1000 + 16'(i * 16'h0111);
         sample_valid = 1'b1;
         sample_data  = d;
         checks++;
         if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, sample_ready); end
         expect_packet(d);
         tick(1);
      end
      sample_valid = 1'b0;
      wait_bytes(4 * NB, 2000);
      tick(busy_len + 8);
      checks++;
      if (got_q.size() != 4 * NB) begin
         errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), 4 * NB);
      end else begin
         for (int i = 0; i < 4 * NB; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
         end
      end
      checks += 2;
      if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
      if (pkt_count !== 8'd4) begin errors++; $display("FAIL b2b_pkt_count: got %0d want 4", pkt_count); end
   endtask

   task automatic test_overflow();
      logic [15:0] d;
      apply_reset();
      busy_len = 3;
      hold_busy = 1'b1;
      tick(2);
      drive_push(16'h0F01);
      expect_packet(16'h0F01);
      tick(4);
      for (int i = 0; i < 6; i++) begin
         d = 16'h0200 + 16'(i);
         sample_valid = 1'b1;
         sample_data  = d;
         checks++;
         if (sample_ready !== (i < 4)) begin errors++; $display("FAIL ovf_ready%0d: got %b want %b", i, sample_ready, (i < 4)); end
         if (i < 4) expect_packet(d);
         tick(1);
      end
      sample_valid = 1'b0;
      tick(5);
      checks += 2;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_held: got %b want 0", sample_ready); end
      hold_busy = 1'b0;
      wait_bytes(5 * NB, 2000);
      tick(busy_len + 8);
      checks++;
      if (got_q.size() != 5 * NB) begin
         errors++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), 5 * NB);
      end else begin
         for (int i = 0; i < 5 * NB; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
         end
      end
      checks += 2;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      if (pkt_count !== 8'd5) begin errors++; $display("FAIL ovf_pkt_count: got %0d want 5", pkt_count); end
   endtask

   task automatic test_seq_wrap();
      logic [15:0] d;
      int w;
      int bad = 0;
      apply_reset();
      busy_len = 2;
      for (int p = 0; p < 257; p++) begin
         w = 0;
         while (sample_ready !== 1'b1 && w < 1000) begin tick(1); w++; end
         if (w >= 1000) begin
            errors++; checks++;
            $display("FAIL wrap_ready_timeout: got %b want 1 at packet %0d", sample_ready, p);
            break;
         end
         d = 16'(p * 7 + 3);
         drive_push(d);
         expect_packet(d);
      end
      wait_bytes(257 * NB, 20000);
      tick(busy_len + 8);
      checks++;
      if (got_q.size() != 257 * NB) begin
         errors++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), 257 * NB);
      end else begin
         for (int i = 0; i < 257 * NB; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               errors++; bad++;
               if (bad < 5) $display("FAIL wrap_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
         end
         checks += 2;
         if (got_q[255 * NB + 1] !== 8'hFF) begin errors++; $display("FAIL wrap_seq255: got %h want ff", got_q[255 * NB + 1]); end
         if (got_q[256 * NB + 1] !== 8'h00) begin errors++; $display("FAIL wrap_seq256: got %h want 00", got_q[256 * NB + 1]); end
      end
      checks++;
      if (pkt_count !== 8'd1) begin errors++; $display("FAIL wrap_pkt_count: got %0d want 1", pkt_count); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      busy_len = 10;
      drive_push(16'h0123);
      drive_push(16'h0456);
      wait_bytes(3, 500);
      checks++;
      if (got_q.size() != 3) begin errors++; $display("FAIL mid_reach_byte2: got %0d bytes want 3", got_q.size()); end
      tick(4);
      reset = 1'b1;
      tick(1);
      checks += 4;
      if (tx_start !== 1'b0) begin errors++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b want 1", sample_ready); end
      if (pkt_count !== 8'd0) begin errors++; $display("FAIL mid_pkt_count: got %0d want 0", pkt_count); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b want 0", overflow); end
      reset = 1'b0;
      got_q.delete();
      exp_q.delete();
      exp_seq = 8'h00;
      tick(30);
      checks++;
      if (got_q.size() != 0) begin errors++; $display("FAIL mid_fifo_empty: got %0d bytes want 0", got_q.size()); end
      drive_push(16'h0777);
      expect_packet(16'h0777);
      wait_bytes(NB, 500);
      tick(busy_len + 8);
      checks++;
      if (got_q.size() != NB) begin
         errors++; $display("FAIL mid_count: got %0d want %0d", got_q.size(), NB);
      end else begin
         for (int i = 0; i < NB; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
         end
      end
      checks++;
      if (pkt_count !== 8'd1) begin errors++; $display("FAIL mid_pkt_after: got %0d want 1", pkt_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_seq_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
